// File: rtl/stopwatch_timer_core_pkg.sv
// Shared types and helpers for the stopwatch/countdown timer core.
package stopwatch_pkg;

    // Width of one BCD digit.
    localparam int BCD_W = 4;

    // Top-level control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Count direction, latched when leaving IDLE.
    typedef enum logic {
        MODE_UP   = 1'b0,
        MODE_DOWN = 1'b1
    } mode_t;

    // Digits 3 and 5 are tens-of-seconds / tens-of-minutes (radix 6).
    // Every other digit is decimal.
    function automatic int radix_of(input int idx);
        if ((idx == 3) || (idx == 5)) begin
            return 6;
        end else begin
            return 10;
        end
    endfunction

endpackage

// File: rtl/stopwatch_timer_core_if.sv
// Control and display bundle between the timer core and its user.
interface stopwatch_timer_core_if #(
    parameter int N_DIGITS = 6
);
    logic                                    start_stop_i;
    logic                                    clear_i;
    logic                                    lap_i;
    logic                                    load_i;
    logic                                    mode_i;
    logic [stopwatch_pkg::BCD_W*N_DIGITS-1:0] load_val_i;
    logic [stopwatch_pkg::BCD_W*N_DIGITS-1:0] digits_o;
    logic [stopwatch_pkg::BCD_W*N_DIGITS-1:0] lap_o;
    logic                                    lap_valid_o;
    logic                                    running_o;
    logic                                    alarm_o;
    logic                                    wrap_o;
    logic                                    tick_o;

    // Controller side: drives commands, observes the count.
    modport master (
        output start_stop_i, clear_i, lap_i, load_i, mode_i, load_val_i,
        input  digits_o, lap_o, lap_valid_o, running_o, alarm_o, wrap_o, tick_o
    );

    // Timer core side.
    modport slave (
        input  start_stop_i, clear_i, lap_i, load_i, mode_i, load_val_i,
        output digits_o, lap_o, lap_valid_o, running_o, alarm_o, wrap_o, tick_o
    );
endinterface

// File: rtl/stopwatch_timer_core_bcd_digit_counter.sv
// One BCD digit with configurable radix, chained through carry/borrow.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter int RADIX = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [BCD_W-1:0] load_val_i,
    input  logic             en_i,
    input  logic             down_i,
    output logic [BCD_W-1:0] digit_o,
    output logic             carry_o,
    output logic             borrow_o
);
    localparam logic [BCD_W-1:0] MAX_DIGIT = BCD_W'(RADIX - 1);

    logic [BCD_W-1:0] digit_q;
    logic [BCD_W-1:0] digit_d;

    // Carry/borrow ripple to the next digit only when this digit rolls over.
    assign carry_o  = en_i && !down_i && (digit_q >= MAX_DIGIT);
    assign borrow_o = en_i && down_i && (digit_q == 4'd0);
    assign digit_o  = digit_q;

    // Next digit: clear, saturating load, or a single up/down step.
    always_comb begin
        digit_d = digit_q;
        if (clr_i) begin
            digit_d = 4'd0;
        end else if (load_i) begin
            digit_d = (load_val_i > MAX_DIGIT) ? MAX_DIGIT : load_val_i;
        end else if (en_i) begin
            if (down_i) begin
                digit_d = (digit_q == 4'd0) ? MAX_DIGIT : (digit_q - 4'd1);
            end else begin
                digit_d = (digit_q >= MAX_DIGIT) ? 4'd0 : (digit_q + 4'd1);
            end
        end else begin
            digit_d = digit_q;
        end
    end

    // Digit register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

endmodule

// File: rtl/stopwatch_timer_core.sv
// Stopwatch / countdown timer: tick prescaler, run/pause FSM, lap capture,
// and a chain of BCD digit counters.
module stopwatch_timer_core
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int TICK_HZ  = 100,
    parameter int N_DIGITS = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    stopwatch_timer_core_if.slave  bus
);
    localparam int              DIV      = CLK_HZ / TICK_HZ;
    localparam int              PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   PRESC_TC = PW'(DIV - 1);
    localparam int              DW       = BCD_W * N_DIGITS;

    state_t         state_q, state_d;
    mode_t          mode_q, mode_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [DW-1:0]  lap_q, lap_d;
    logic           lap_valid_q, lap_valid_d;
    logic           running_q, running_d;
    logic           alarm_q, alarm_d;
    logic           wrap_q, wrap_d;
    logic           tick_q, tick_d;

    logic [DW-1:0]       count_s;
    logic [N_DIGITS:0]   en_s;
    logic [N_DIGITS-1:0] carry_s;
    logic [N_DIGITS-1:0] borrow_s;
    logic                step_s;
    logic                down_s;
    logic                load_acc_s;
    logic                count_zero_s;
    logic                down_done_s;

    // A step fires on prescaler terminal count in RUN; clear overrides it.
    assign step_s       = (state_q == ST_RUN) && (presc_q == PRESC_TC) && !bus.clear_i;
    assign down_s       = (mode_q == MODE_DOWN);
    // Load is accepted everywhere except RUN, and loses to clear.
    assign load_acc_s   = bus.load_i && !bus.clear_i && (state_q != ST_RUN);
    assign count_zero_s = (count_s == {DW{1'b0}});
    // Decrementing a count of exactly one is what lands on zero.
    assign down_done_s  = step_s && down_s && (count_s == DW'(1));
    assign en_s[0]      = step_s;

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            bcd_digit_counter #(
                .RADIX (radix_of(gi))
            ) u_digit (
                .clk        (clk),
                .rst        (rst),
                .clr_i      (bus.clear_i),
                .load_i     (load_acc_s),
                .load_val_i (bus.load_val_i[gi*BCD_W +: BCD_W]),
                .en_i       (en_s[gi]),
                .down_i     (down_s),
                .digit_o    (count_s[gi*BCD_W +: BCD_W]),
                .carry_o    (carry_s[gi]),
                .borrow_o   (borrow_s[gi])
            );
            assign en_s[gi+1] = carry_s[gi] | borrow_s[gi];
        end
    endgenerate

    // Next state, prescaler, lap capture and output pulses.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        presc_d     = presc_q;
        lap_d       = lap_q;
        lap_valid_d = lap_valid_q;
        if (bus.clear_i) begin
            state_d     = ST_IDLE;
            presc_d     = {PW{1'b0}};
            lap_d       = {DW{1'b0}};
            lap_valid_d = 1'b0;
        end else begin
            // Lap sees the count before any update of this cycle.
            if (bus.lap_i && (state_q != ST_IDLE)) begin
                lap_d       = count_s;
                lap_valid_d = 1'b1;
            end else begin
                lap_d       = lap_q;
                lap_valid_d = lap_valid_q;
            end
            case (state_q)
                ST_RUN: begin
                    presc_d = (presc_q == PRESC_TC) ? {PW{1'b0}} : (presc_q + PW'(1));
                    if (down_done_s) begin
                        state_d = ST_DONE;
                    end else if (bus.start_stop_i) begin
                        state_d = ST_PAUSE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_IDLE: begin
                    if (bus.load_i) begin
                        presc_d = {PW{1'b0}};
                    end else if (bus.start_stop_i && !(bus.mode_i && count_zero_s)) begin
                        state_d = ST_RUN;
                        mode_d  = bus.mode_i ? MODE_DOWN : MODE_UP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PAUSE: begin
                    if (bus.load_i) begin
                        presc_d = {PW{1'b0}};
                    end else if (bus.start_stop_i) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_DONE: begin
                    if (bus.load_i) begin
                        presc_d = {PW{1'b0}};
                        state_d = ST_IDLE;
                    end else if (bus.start_stop_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        running_d = (state_d == ST_RUN);
        alarm_d   = down_done_s;
        wrap_d    = carry_s[N_DIGITS-1];
        tick_d    = step_s;
    end

    // Control state and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_UP;
            presc_q     <= {PW{1'b0}};
            lap_q       <= {DW{1'b0}};
            lap_valid_q <= 1'b0;
            running_q   <= 1'b0;
            alarm_q     <= 1'b0;
            wrap_q      <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            presc_q     <= presc_d;
            lap_q       <= lap_d;
            lap_valid_q <= lap_valid_d;
            running_q   <= running_d;
            alarm_q     <= alarm_d;
            wrap_q      <= wrap_d;
            tick_q      <= tick_d;
        end
    end

    assign bus.digits_o    = count_s;
    assign bus.lap_o       = lap_q;
    assign bus.lap_valid_o = lap_valid_q;
    assign bus.running_o   = running_q;
    assign bus.alarm_o     = alarm_q;
    assign bus.wrap_o      = wrap_q;
    assign bus.tick_o      = tick_q;

endmodule

// File: doc/stopwatch_timer_core.md
# stopwatch_timer_core

Parametrised stopwatch/countdown timer core that replaces the fixed-function stopwatch counter inside the board tops. It divides the system clock into a configurable tick and keeps an N-digit BCD time count (centiseconds, seconds, minutes, then decimal). The count runs up (stopwatch) or down (timer) with pause/resume, lap capture and preload. Countdown expiry raises an alarm pulse that drives the audio/alarm path; digit outputs feed the display/LED mux.

## Interface
- CLK_HZ, 100_000_000: system clock frequency.
- TICK_HZ, 100: count resolution; DIV = CLK_HZ/TICK_HZ, integer, ≥2.
- N_DIGITS, 6: BCD digits, ≥4. Digits 3 and 5 are radix 6; all others are radix 10. Digit 0 is least significant.

- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start_stop_i  in  1  one-cycle pulse (already debounced); toggles run/pause.
- clear_i  in  1  one-cycle pulse; zeroes everything and returns to IDLE.
- lap_i  in  1  one-cycle pulse; captures the current count.
- load_i  in  1  one-cycle pulse; loads load_val_i.
- mode_i  in  1  0 = count up, 1 = count down. Latched only on the IDLE→RUN transition.
- load_val_i  in  4*N_DIGITS  BCD preload value.
- digits_o  out  4*N_DIGITS  current count, registered.
- lap_o  out  4*N_DIGITS  last lap capture.
- lap_valid_o  out  1  high once a lap has been captured since the last clear.
- running_o  out  1  high in RUN.
- alarm_o  out  1  one-cycle pulse when a countdown reaches zero.
- wrap_o  out  1  one-cycle pulse when an up-count wraps from max to zero.
- tick_o  out  1  one-cycle pulse on every count step.

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- IDLE:
  - start_stop → RUN, latching mode_i.
  - If the latched mode is down and the count is all-zero, start is ignored and the block stays in IDLE.
- RUN:
  - start_stop → PAUSE.
  - A down-count reaching zero → DONE.
- PAUSE: start_stop → RUN. The latched mode is kept.
- DONE: start_stop → IDLE; the count stays zero.
- clear_i, in any state:
  - → IDLE.
  - count, prescaler, lap_o and lap_valid_o all go to 0.
- load_i:
  - Accepted in IDLE, PAUSE and DONE. Ignored in RUN.
  - DONE+load → IDLE.
  - Each loaded digit saturates to radix−1.
  - The prescaler is zeroed.
- Priority within a single cycle: clear > load > start_stop.
- lap_i is accepted in any state except IDLE and captures the pre-update count.
  - lap_i together with start_stop stores the count as it was before the stop.
  - lap_i together with clear: clear wins and no lap is captured.
- Prescaler:
  - Counts 0..DIV−1 and advances only in RUN.
  - Holds its value in PAUSE, so the fractional tick is preserved.
  - Terminal count produces a step.
- Step:
  - Up mode: ripple BCD increment with per-digit radix. All digits at max wrap to 0, pulse wrap_o, and the block keeps running.
  - Down mode: ripple BCD decrement. A digit at 0 borrows and becomes radix−1. A result of all-zero → DONE with alarm_o pulsed.
- mode_i changes outside the IDLE→RUN transition have no effect.

## Timing
- Reset values: state IDLE; digits_o, lap_o, lap_valid_o, running_o, alarm_o, wrap_o and tick_o all 0; prescaler 0.
- A start_stop pulse in cycle t gives running_o=1 in t+1.
- The first step occurs DIV cycles after RUN entry from a zeroed prescaler.
- tick_o and the updated digits_o appear in the same cycle, one cycle after the prescaler terminal count.
- alarm_o is asserted in the same cycle that digits_o first reads zero and running_o drops.
- A stop pulse in the cycle of a terminal count: the step is taken, then the block pauses.
- Asynchronous reset mid-run: all outputs return to 0 immediately. No alarm is emitted.

## Structure
- Package stopwatch_pkg holds:
  - the state enum (IDLE/RUN/PAUSE/DONE);
  - the mode enum (UP/DOWN);
  - the function radix_of(idx);
  - the BCD digit width constant, 4.
- Sub-module bcd_digit_counter:
  - Inputs: radix parameter, enable, up/down select, load.
  - Outputs: carry and borrow.
  - Instantiated N_DIGITS times in a generate loop, chained by carry/borrow.
- The prescaler and FSM live in the core.

## Test plan
All scenarios use CLK_HZ=1000 and TICK_HZ=100, so DIV=10.

- Up count: reset, start, wait 1000 cycles → digits_o = 00:01.00 (BCD 0x000100), tick_o pulsed 100 times, running_o=1.
- Wrap: load 59:59.99 in IDLE, start, wait 10 cycles → digits_o=0, wrap_o for one cycle, running_o stays 1.
- Countdown: mode_i=1, load 00:00.03, start → after 30 cycles digits_o=0, alarm_o for one cycle, state DONE, running_o=0. A further start returns to IDLE. A start in IDLE with the count at zero stays in IDLE.
- Pause: start, stop after 15 cycles (count 00:00.01), wait 100, resume → the next step comes 5 cycles later.
- Lap and priority:
  - lap_i with start_stop at count 00:00.07 → lap_o = 00:00.07, lap_valid_o=1, state PAUSE.
  - clear with start_stop → IDLE with everything zero.
  - load during RUN → ignored.
- Saturation and reset: load digit 3 = 9 → 5 is read back. Assert rst mid-run → all outputs 0 asynchronously.
